booth_radix4_multiplier: RTL and testbench

//  Parametrised radix-4 (modified Booth) sequential multiplier; successor to the radix-2 Booth datapath.

---
 rtl/booth_radix4_multiplier.sv | 110 +++++++++++
 tb/tb_booth_radix4_multiplier.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/booth_radix4_multiplier.sv
// Radix-4 modified-Booth sequential multiplier with valid/ready handshakes, signed/unsigned per transaction.
// Optional macro BOOTH_ZERO_SKIP_EN: zero operands finish one cycle after acceptance.
module booth_radix4_multiplier #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   input  logic               signed_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);
   localparam int ITER  = WIDTH/2 + 1;
   localparam int CNT_W = $clog2(ITER + 1);
   localparam int AW    = WIDTH + 3;
   localparam int PW    = 2*WIDTH + 6;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [AW-1:0]      r_a;
   logic [PW-1:0]      r_p;
   logic [2*WIDTH-1:0] r_product;
   logic               r_out_valid;

   logic               w_sext_a;
   logic               w_sext_b;
   logic [AW-1:0]      w_a_ext;
   logic [WIDTH+1:0]   w_b_ext;
   logic [AW-1:0]      w_addend;
   logic [AW-1:0]      w_upper;
   logic [PW-1:0]      w_next;

   assign w_sext_a = signed_mode & multiplicand[WIDTH-1];
   assign w_sext_b = signed_mode & multiplier[WIDTH-1];
   assign w_a_ext  = {{3{w_sext_a}}, multiplicand};
   assign w_b_ext  = {{2{w_sext_b}}, multiplier};

   always_comb begin
      w_addend = '0;
      case (r_p[2:0])
         3'b001, 3'b010: w_addend = r_a;
         3'b011:         w_addend = r_a << 1;
         3'b100:         w_addend = -(r_a << 1);
         3'b101, 3'b110: w_addend = -r_a;
         default:        w_addend = '0;
      endcase
   end

   // Add into the accumulator half, then arithmetic shift the whole register right by 2.
   assign w_upper = r_p[PW-1:WIDTH+3] + w_addend;
   assign w_next  = {{2{w_upper[AW-1]}}, w_upper, r_p[WIDTH+2:2]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_a         <= '0;
         r_p         <= '0;
         r_product   <= '0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a     <= w_a_ext;
                  r_p     <= {{AW{1'b0}}, w_b_ext, 1'b0};
                  r_cnt   <= CNT_W'(ITER);
                  r_state <= S_BUSY;
`ifdef BOOTH_ZERO_SKIP_EN
                  // A single all-zero step yields product 0 one cycle after acceptance.
                  if (multiplicand == '0 || multiplier == '0) begin
                     r_a   <= '0;
                     r_p   <= '0;
                     r_cnt <= CNT_W'(1);
                  end
`endif
               end
            end
            S_BUSY: begin
               r_p   <= w_next;
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == CNT_W'(1)) begin
                  r_state     <= S_DONE;
                  r_product   <= w_next[2*WIDTH:1];
                  r_out_valid <= 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign out_valid = r_out_valid;
   assign product   = r_product;
endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// Scoreboard bench for booth_radix4_multiplier at WIDTH=16: directed cases plus a random signed/unsigned sweep.
module tb_booth_radix4_multiplier;
   localparam int W    = 16;
   localparam int ITER = W/2 + 1;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic           in_valid = 1'b0;
   logic           signed_mode = 1'b0;
   logic           out_ready = 1'b0;
   logic [W-1:0]   opa = '0;
   logic [W-1:0]   opb = '0;
   logic           in_ready;
   logic           out_valid;
   logic           busy;
   logic [2*W-1:0] product;

   booth_radix4_multiplier #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .multiplicand(opa), .multiplier(opb), .signed_mode(signed_mode),
      .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [2*W-1:0] prod;
      int             lat;
   } exp_t;

   exp_t sb_q[$];
   int   acc_q[$];
   int   checks = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Reference: plain integer multiply of the interpreted operands.
   function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      longint xs, ys, p;
      xs = s ? longint'($signed(x)) : longint'(x);
      ys = s ? longint'($signed(y)) : longint'(y);
      p  = xs * ys;
      return p[2*W-1:0];
   endfunction

   function automatic int ref_lat(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef BOOTH_ZERO_SKIP_EN
      if (x == '0 || y == '0) return 1;
`endif
      return ITER;
   endfunction

   // Monitor: samples on the falling edge, away from the active edge.
   logic           prev_ov = 1'b0;
   logic           prev_or = 1'b0;
   logic [2*W-1:0] prev_prod = '0;
   exp_t           mon_e;

   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_ov = 1'b0;
            prev_or = 1'b0;
         end else begin
            if (in_valid && in_ready) acc_q.push_back(cyc + 1);
            if (out_valid) chk("in_ready_low_in_done", {63'b0, in_ready}, 64'd0);
            if (prev_ov && !prev_or) begin
               chk("hold_out_valid", {63'b0, out_valid}, 64'd1);
               chk("hold_product", {32'b0, product}, {32'b0, prev_prod});
            end
            if (prev_ov && prev_or) begin
               chk("release_out_valid", {63'b0, out_valid}, 64'd0);
               chk("release_in_ready", {63'b0, in_ready}, 64'd1);
               chk("release_product_hold", {32'b0, product}, {32'b0, prev_prod});
            end
            if (out_valid && !prev_ov) begin
               if (sb_q.size() == 0 || acc_q.size() == 0) fail_now("spurious_out_valid");
               else chk("latency", 64'(cyc - acc_q.pop_front()), 64'(sb_q[0].lat));
            end
            if (out_valid && out_ready && sb_q.size() != 0) begin
               mon_e = sb_q.pop_front();
               chk("product", {32'b0, product}, {32'b0, mon_e.prod});
            end
            prev_ov   = out_valid;
            prev_or   = out_ready;
            prev_prod = product;
         end
      end
   end

   task automatic wait_in_ready();
      int n = 0;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   // One transaction: issue, wait for result, stall `hold` cycles (optionally pulsing in_valid), accept.
   task automatic run(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input int hold, input logic pulse);
      exp_t e;
      int   n;
      wait_in_ready();
      if (!in_ready) begin
         fail_now("in_ready_timeout");
         return;
      end
      e.prod = ref_mul(x, y, s);
      e.lat  = ref_lat(x, y);
      sb_q.push_back(e);
      opa = x; opb = y; signed_mode = s; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!out_valid) begin
         fail_now("out_valid_timeout");
         sb_q.delete();
         acc_q.delete();
         return;
      end
      repeat (hold) begin
         in_valid = pulse;
         opa = W'($urandom); opb = W'($urandom); signed_mode = 1'($urandom);
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   function automatic logic [W-1:0] pick();
      logic [W-1:0] corner [5];
      corner[0] = '0;
      corner[1] = {1'b1, {(W-1){1'b0}}};
      corner[2] = {1'b0, {(W-1){1'b1}}};
      corner[3] = '1;
      corner[4] = W'(1);
      if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
      return W'($urandom);
   endfunction

   initial begin
      #500000;
      $display("FAIL global_timeout (cycle %0d)", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      #2 reset = 1'b1;
      #1;
      chk("reset_in_ready", {63'b0, in_ready}, 64'd1);
      chk("reset_out_valid", {63'b0, out_valid}, 64'd0);
      chk("reset_busy", {63'b0, busy}, 64'd0);
      chk("reset_product", {32'b0, product}, 64'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      run(16'hFFFD, 16'h0007, 1'b1, 0, 1'b0);
      run(16'hFFFF, 16'hFFFF, 1'b0, 1, 1'b0);
      run(16'hFFFF, 16'hFFFF, 1'b1, 0, 1'b0);
      run(16'h8000, 16'h8000, 1'b1, 0, 1'b0);
      run(16'h8000, 16'h7FFF, 1'b1, 2, 1'b0);
      run(16'hFFFD, 16'h0007, 1'b1, 5, 1'b1);

      // Abort mid-computation with an asynchronous reset.
      wait_in_ready();
      sb_q.push_back('{prod: ref_mul(16'h1234, 16'h5678, 1'b1), lat: ITER});
      opa = 16'h1234; opb = 16'h5678; signed_mode = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      chk("abort_in_ready", {63'b0, in_ready}, 64'd1);
      chk("abort_out_valid", {63'b0, out_valid}, 64'd0);
      chk("abort_busy", {63'b0, busy}, 64'd0);
      chk("abort_product", {32'b0, product}, 64'd0);
      if (sb_q.size() != 0) void'(sb_q.pop_back());
      if (acc_q.size() != 0) void'(acc_q.pop_back());
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      run(16'h0005, 16'h0006, 1'b0, 0, 1'b0);

      run(16'h0000, 16'h1234, 1'b0, 0, 1'b0);
      run(16'h0000, 16'h1234, 1'b1, 1, 1'b0);
      run(16'h4321, 16'h0000, 1'b1, 0, 1'b0);

      for (int i = 0; i < 150; i++)
         run(pick(), pick(), 1'($urandom), $urandom_range(0, 2), 1'($urandom));

      repeat (4) @(posedge clk);
      if (sb_q.size() != 0) fail_now("scoreboard_not_empty");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
